// File: rtl/ex_hazard_scheduler_pkg.sv
// Shared constants, FSM state type and helpers for the EX issue scheduler.
package ex_hazard_scheduler_pkg;

  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned CNT_WIDTH = 2;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned FLUSH_W   = 3;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    SCH_RUN    = 2'd0,
    SCH_FLUSH  = 2'd1,
    SCH_HALTED = 2'd2
  } sch_state_t;

  function automatic logic [3:0] sat_in_flight(input int unsigned total);
    return (total > 32'd15) ? 4'hF : 4'(total);
  endfunction

endpackage

// File: rtl/ex_hazard_scheduler_if.sv
// Decode/Execute/Writeback signals seen by the issue scheduler.
interface ex_hazard_scheduler_if;
  import ex_hazard_scheduler_pkg::*;

  logic     I_LOCK;
  logic     I_GPUStallSignal;
  logic     I_Issue_Valid;
  reg_idx_t I_Src1Idx;
  logic     I_Src1Used;
  reg_idx_t I_Src2Idx;
  logic     I_Src2Used;
  logic     I_UsesCC;
  reg_idx_t I_DestRegIdx;
  logic     I_RegWEn;
  logic     I_CCWEn;
  logic     I_IsHalt;
  logic     I_BranchTaken;
  logic     I_WB_Valid;
  logic     I_WB_RegWEn;
  reg_idx_t I_WB_DestRegIdx;
  logic     I_WB_CCWEn;
  logic     O_IssueGrant;
  logic     O_Stall;
  logic     O_Flush;
  logic     O_Halted;
  logic     O_ScbError;
  logic [3:0] O_InFlight;

  modport master (
    output I_LOCK, I_GPUStallSignal, I_Issue_Valid, I_Src1Idx, I_Src1Used,
           I_Src2Idx, I_Src2Used, I_UsesCC, I_DestRegIdx, I_RegWEn, I_CCWEn,
           I_IsHalt, I_BranchTaken, I_WB_Valid, I_WB_RegWEn, I_WB_DestRegIdx,
           I_WB_CCWEn,
    input  O_IssueGrant, O_Stall, O_Flush, O_Halted, O_ScbError, O_InFlight
  );

  modport slave (
    input  I_LOCK, I_GPUStallSignal, I_Issue_Valid, I_Src1Idx, I_Src1Used,
           I_Src2Idx, I_Src2Used, I_UsesCC, I_DestRegIdx, I_RegWEn, I_CCWEn,
           I_IsHalt, I_BranchTaken, I_WB_Valid, I_WB_RegWEn, I_WB_DestRegIdx,
           I_WB_CCWEn,
    output O_IssueGrant, O_Stall, O_Flush, O_Halted, O_ScbError, O_InFlight
  );

endinterface

// File: rtl/ex_hazard_scheduler_reg_scoreboard.sv
// Per-register in-flight write counters: one increment and one decrement port,
// zero/full flags from the registered counts and a pulse on retire-against-zero.
module reg_scoreboard #(
  parameter  int unsigned NUM_REGS  = ex_hazard_scheduler_pkg::NUM_REGS,
  parameter  int unsigned CNT_WIDTH = ex_hazard_scheduler_pkg::CNT_WIDTH,
  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                inc_en,
  input  logic [IDX_W-1:0]                    inc_idx,
  input  logic                                dec_en,
  input  logic [IDX_W-1:0]                    dec_idx,
  output logic [NUM_REGS-1:0]                 zero,
  output logic [NUM_REGS-1:0]                 full,
  output logic                                err,
  output logic [NUM_REGS-1:0][CNT_WIDTH-1:0]  cnt_nxt
);

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [NUM_REGS-1:0]                inc_hit;
  logic [NUM_REGS-1:0]                dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    zero    = '0;
    full    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc_hit[i] = inc_en && (inc_idx == IDX_W'(i));
      dec_hit[i] = dec_en && (dec_idx == IDX_W'(i));
      zero[i]    = (cnt_q[i] == '0);
      full[i]    = (cnt_q[i] == '1);
    end
  end

  // Matching inc/dec on one index cancel; an empty counter never underflows.
  always_comb begin
    cnt_nxt = cnt_q;
    err     = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (dec_hit[i] && zero[i])
        err = 1'b1;
      if (inc_hit[i] && !dec_hit[i] && !full[i])
        cnt_nxt[i] = cnt_q[i] + CNT_WIDTH'(1);
      else if (dec_hit[i] && !inc_hit[i] && !zero[i])
        cnt_nxt[i] = cnt_q[i] - CNT_WIDTH'(1);
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_nxt;
  end

endmodule

// File: rtl/ex_hazard_scheduler.sv
// Single registered issue point between Decode and Execute: RAW/CC hazard
// stalls, post-branch flush window and sticky HALT. State moves on negedge.
module ex_hazard_scheduler
  import ex_hazard_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REGS     = ex_hazard_scheduler_pkg::NUM_REGS,
  parameter int unsigned CNT_WIDTH    = ex_hazard_scheduler_pkg::CNT_WIDTH,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET_N,
  ex_hazard_scheduler_if.slave  sch
);

  sch_state_t                         state_q, state_d;
  logic [FLUSH_W-1:0]                 flush_cnt_q, flush_cnt_d;
  logic                               flush_q, halted_q, err_q;
  logic [3:0]                         in_flight_q, in_flight_d;

  logic [NUM_REGS-1:0]                reg_zero, reg_full;
  logic                               reg_err;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] reg_cnt_nxt;
  logic [0:0]                         cc_zero, cc_full;
  logic                               cc_err;
  logic [0:0][CNT_WIDTH-1:0]          cc_cnt_nxt_unused;

  logic hazard, grant;

  reg_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_WIDTH(CNT_WIDTH)) u_reg_scb (
    .clk     (I_CLOCK),
    .rst_n   (I_RESET_N),
    .inc_en  (grant & sch.I_RegWEn),
    .inc_idx (sch.I_DestRegIdx),
    .dec_en  (sch.I_WB_Valid & sch.I_WB_RegWEn),
    .dec_idx (sch.I_WB_DestRegIdx),
    .zero    (reg_zero),
    .full    (reg_full),
    .err     (reg_err),
    .cnt_nxt (reg_cnt_nxt)
  );

  reg_scoreboard #(.NUM_REGS(1), .CNT_WIDTH(CNT_WIDTH)) u_cc_scb (
    .clk     (I_CLOCK),
    .rst_n   (I_RESET_N),
    .inc_en  (grant & sch.I_CCWEn),
    .inc_idx (1'b0),
    .dec_en  (sch.I_WB_Valid & sch.I_WB_CCWEn),
    .dec_idx (1'b0),
    .zero    (cc_zero),
    .full    (cc_full),
    .err     (cc_err),
    .cnt_nxt (cc_cnt_nxt_unused)
  );

  // Flags come from registered counts only, so a same-cycle retire cannot clear a hazard.
  always_comb begin
    hazard = (sch.I_Src1Used & ~reg_zero[sch.I_Src1Idx])
           | (sch.I_Src2Used & ~reg_zero[sch.I_Src2Idx])
           | (sch.I_UsesCC   & ~cc_zero[0])
           | (sch.I_RegWEn   &  reg_full[sch.I_DestRegIdx])
           | (sch.I_CCWEn    &  cc_full[0]);
    grant  = I_RESET_N & sch.I_Issue_Valid & sch.I_LOCK & ~sch.I_GPUStallSignal
           & ~hazard & (state_q == SCH_RUN) & ~sch.I_BranchTaken;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (sch.I_LOCK) begin
      case (state_q)
        SCH_RUN: begin
          if (sch.I_BranchTaken) begin
            state_d     = SCH_FLUSH;
            flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
          end else if (grant && sch.I_IsHalt) begin
            state_d = SCH_HALTED;
          end
        end
        SCH_FLUSH: begin
          if (sch.I_BranchTaken) begin
            flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
          end else if (flush_cnt_q <= FLUSH_W'(1)) begin
            state_d     = SCH_RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
          end
        end
        SCH_HALTED: ;
        default: state_d = SCH_RUN;
      endcase
    end
  end

  always_comb begin
    int unsigned total;
    total = 0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      total = total + 32'(reg_cnt_nxt[i]);
    in_flight_d = sat_in_flight(total);
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q     <= SCH_RUN;
      flush_cnt_q <= '0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= (state_d == SCH_FLUSH);
      halted_q    <= (state_d == SCH_HALTED);
      err_q       <= err_q | reg_err | cc_err;
      in_flight_q <= in_flight_d;
    end
  end

  assign sch.O_IssueGrant = grant;
  assign sch.O_Stall      = I_RESET_N & sch.I_Issue_Valid & ~grant;
  assign sch.O_Flush      = flush_q;
  assign sch.O_Halted     = halted_q;
  assign sch.O_ScbError   = err_q;
  assign sch.O_InFlight   = in_flight_q;

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Directed bench for ex_hazard_scheduler: expected outputs are queued as each
// step is driven and popped/compared at the following posedge.
module tb_ex_hazard_scheduler;

  logic clk   = 1'b1;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_hazard_scheduler_if sch_if();

  ex_hazard_scheduler #(.FLUSH_CYCLES(2)) dut (
    .I_CLOCK   (clk),
    .I_RESET_N (rst_n),
    .sch       (sch_if.slave)
  );

  typedef struct {
    string      tag;
    logic       grant;
    logic       stall;
    logic       flush;
    logic       halted;
    logic       err;
    logic [3:0] in_flight;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic g, input logic s, input logic f,
                          input logic h, input logic e, input logic [3:0] inf);
    exp_t x;
    x.tag = tag; x.grant = g; x.stall = s; x.flush = f;
    x.halted = h; x.err = e; x.in_flight = inf;
    exp_q.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    x = exp_q.pop_front();
    chk({x.tag, ".grant"},    4'(sch_if.O_IssueGrant), 4'(x.grant));
    chk({x.tag, ".stall"},    4'(sch_if.O_Stall),      4'(x.stall));
    chk({x.tag, ".flush"},    4'(sch_if.O_Flush),      4'(x.flush));
    chk({x.tag, ".halted"},   4'(sch_if.O_Halted),     4'(x.halted));
    chk({x.tag, ".scberr"},   4'(sch_if.O_ScbError),   4'(x.err));
    chk({x.tag, ".inflight"}, sch_if.O_InFlight,       x.in_flight);
  endtask

  // Outputs observed mid-cycle (posedge), then the negedge update is taken.
  task automatic step(input string tag, input logic g, input logic s, input logic f,
                      input logic h, input logic e, input logic [3:0] inf);
    push_exp(tag, g, s, f, h, e, inf);
    @(posedge clk);
    compare_out();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    sch_if.I_LOCK = 1'b1;           sch_if.I_GPUStallSignal = 1'b0;
    sch_if.I_Issue_Valid = 1'b0;    sch_if.I_Src1Idx = '0;
    sch_if.I_Src1Used = 1'b0;       sch_if.I_Src2Idx = '0;
    sch_if.I_Src2Used = 1'b0;       sch_if.I_UsesCC = 1'b0;
    sch_if.I_DestRegIdx = '0;       sch_if.I_RegWEn = 1'b0;
    sch_if.I_CCWEn = 1'b0;          sch_if.I_IsHalt = 1'b0;
    sch_if.I_BranchTaken = 1'b0;    sch_if.I_WB_Valid = 1'b0;
    sch_if.I_WB_RegWEn = 1'b0;      sch_if.I_WB_DestRegIdx = '0;
    sch_if.I_WB_CCWEn = 1'b0;
  endtask

  task automatic wr(input logic [3:0] d);
    sch_if.I_Issue_Valid = 1'b1; sch_if.I_RegWEn = 1'b1; sch_if.I_DestRegIdx = d;
  endtask

  task automatic wb(input logic [3:0] d);
    sch_if.I_WB_Valid = 1'b1; sch_if.I_WB_RegWEn = 1'b1; sch_if.I_WB_DestRegIdx = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    sch_if.I_Issue_Valid = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 4'd0);
    rst_n = 1'b1;

    // RAW stall on r3
    idle(); wr(3);                           step("t1_grant_r3",     1, 0, 0, 0, 0, 4'd0);
    idle(); wr(4); sch_if.I_Src1Idx = 4'd3; sch_if.I_Src1Used = 1'b1;
                                             step("t1_raw_stall",    0, 1, 0, 0, 0, 4'd1);
                                             step("t1_raw_stall2",   0, 1, 0, 0, 0, 4'd1);
    wb(3);                                   step("t1_wb_no_bypass", 0, 1, 0, 0, 0, 4'd1);
    sch_if.I_WB_Valid = 1'b0;                step("t1_grant_r4",     1, 0, 0, 0, 0, 4'd0);
    idle(); wb(4);                           step("t1_retire_r4",    0, 0, 0, 0, 0, 4'd1);

    // CC hazard
    idle(); sch_if.I_Issue_Valid = 1'b1; sch_if.I_CCWEn = 1'b1;
                                             step("t2_grant_cmp",    1, 0, 0, 0, 0, 4'd0);
    idle(); sch_if.I_Issue_Valid = 1'b1; sch_if.I_UsesCC = 1'b1;
                                             step("t2_cc_stall",     0, 1, 0, 0, 0, 4'd0);
    sch_if.I_WB_Valid = 1'b1; sch_if.I_WB_CCWEn = 1'b1;
                                             step("t2_cc_wb",        0, 1, 0, 0, 0, 4'd0);
    sch_if.I_WB_Valid = 1'b0; sch_if.I_WB_CCWEn = 1'b0;
                                             step("t2_grant_brz",    1, 0, 0, 0, 0, 4'd0);

    // Flush window of 2, then reload by a second branch
    idle(); sch_if.I_BranchTaken = 1'b1;     step("t3_branch",       0, 0, 0, 0, 0, 4'd0);
    idle(); sch_if.I_Issue_Valid = 1'b1;     step("t3_flush0",       0, 1, 1, 0, 0, 4'd0);
                                             step("t3_flush1",       0, 1, 1, 0, 0, 4'd0);
                                             step("t3_run",          1, 0, 0, 0, 0, 4'd0);
    sch_if.I_IsHalt = 1'b1; sch_if.I_BranchTaken = 1'b1;
                                             step("t3_branch_v_halt",0, 1, 0, 0, 0, 4'd0);
    idle(); sch_if.I_BranchTaken = 1'b1;     step("t3_reload",       0, 0, 1, 0, 0, 4'd0);
    idle();                                  step("t3_flush_b1",     0, 0, 1, 0, 0, 4'd0);
                                             step("t3_flush_b2",     0, 0, 1, 0, 0, 4'd0);
                                             step("t3_run_b",        0, 0, 0, 0, 0, 4'd0);

    // Counter saturation and simultaneous grant/retire on r5
    idle(); wr(5);                           step("t4_g1",           1, 0, 0, 0, 0, 4'd0);
                                             step("t4_g2",           1, 0, 0, 0, 0, 4'd1);
    wb(5);                                   step("t4_g_and_wb",     1, 0, 0, 0, 0, 4'd2);
    idle(); wr(5);                           step("t4_g3",           1, 0, 0, 0, 0, 4'd2);
                                             step("t4_sat_stall",    0, 1, 0, 0, 0, 4'd3);
    wb(5);                                   step("t4_sat_wb",       0, 1, 0, 0, 0, 4'd3);
    idle(); wb(5);                           step("t4_drain1",       0, 0, 0, 0, 0, 4'd2);
                                             step("t4_drain2",       0, 0, 0, 0, 0, 4'd1);
    idle();                                  step("t4_empty",        0, 0, 0, 0, 0, 4'd0);

    // GPU stall and lock-during-flush
    idle(); wr(5); sch_if.I_GPUStallSignal = 1'b1;
                                             step("t6_gpu_block",    0, 1, 0, 0, 0, 4'd0);
    idle(); sch_if.I_Issue_Valid = 1'b1; sch_if.I_Src1Idx = 4'd5; sch_if.I_Src1Used = 1'b1;
                                             step("t6_r5_clear",     1, 0, 0, 0, 0, 4'd0);
    idle(); sch_if.I_BranchTaken = 1'b1;     step("t6_branch",       0, 0, 0, 0, 0, 4'd0);
    idle(); sch_if.I_LOCK = 1'b0; sch_if.I_Issue_Valid = 1'b1;
                                             step("t6_lock_hold0",   0, 1, 1, 0, 0, 4'd0);
                                             step("t6_lock_hold1",   0, 1, 1, 0, 0, 4'd0);
    sch_if.I_LOCK = 1'b1;                    step("t6_flush_c1",     0, 1, 1, 0, 0, 4'd0);
                                             step("t6_flush_c2",     0, 1, 1, 0, 0, 4'd0);
                                             step("t6_run",          1, 0, 0, 0, 0, 4'd0);

    // Scoreboard error, halt, retire while halted, async reset
    idle(); wb(7);                           step("t5_bad_retire",   0, 0, 0, 0, 0, 4'd0);
    idle();                                  step("t5_err_sticky",   0, 0, 0, 0, 1, 4'd0);
    idle(); wr(2);                           step("t5_grant_r2",     1, 0, 0, 0, 1, 4'd0);
    idle(); wr(3);                           step("t5_grant_r3",     1, 0, 0, 0, 1, 4'd1);
    idle(); sch_if.I_Issue_Valid = 1'b1; sch_if.I_IsHalt = 1'b1;
                                             step("t5_grant_halt",   1, 0, 0, 0, 1, 4'd2);
    idle(); sch_if.I_Issue_Valid = 1'b1; wb(2);
                                             step("t5_halted_wb",    0, 1, 0, 1, 1, 4'd2);
    idle(); sch_if.I_Issue_Valid = 1'b1;     step("t5_halted_stall", 0, 1, 0, 1, 1, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("t5_async_reset", 0, 0, 0, 0, 0, 4'd0);
    compare_out();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(); sch_if.I_Issue_Valid = 1'b1; sch_if.I_Src1Idx = 4'd3; sch_if.I_Src1Used = 1'b1;
                                             step("t5_post_reset",   1, 0, 0, 0, 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
